// File: rtl/vga_pkg.sv
// Shared types and constants for the grayscale VGA frame path.
// Ports: none (package: timing totals, widths, FSM state enum).
package vga_pkg;

   localparam int unsigned H_TOTAL   = 800;
   localparam int unsigned V_TOTAL   = 525;
   localparam int unsigned IMG_W_DEF = 100;
   localparam int unsigned IMG_H_DEF = 100;
   localparam int unsigned ADDR_W    = 16;

   // Counters must reach the longer of the two totals.
   localparam int unsigned CNT_W =
      $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

   function automatic int unsigned frame_size(
      input int unsigned w,
      input int unsigned h
   );
      return w * h;
   endfunction

   localparam int unsigned FRAME_SIZE = frame_size(IMG_W_DEF, IMG_H_DEF);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VS,
      CAPTURE,
      DONE
   } state_t;

endpackage

// File: rtl/vga_sync_tracker.sv
// Sync edge detector with line/pixel position counters.
// Ports: clk_25Mhz, rst_n, Hsync, Vsync in; hRise, vRise, hCnt, vCnt out.
module vga_sync_tracker
   import vga_pkg::*;
(
   input  logic             clk_25Mhz,
   input  logic             rst_n,
   input  logic             Hsync,
   input  logic             Vsync,
   output logic             hRise,
   output logic             vRise,
   output logic [CNT_W-1:0] hCnt,
   output logic [CNT_W-1:0] vCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic hsync_q;
   logic vsync_q;

   assign hRise = Hsync & ~hsync_q;
   assign vRise = Vsync & ~vsync_q;

   always_ff @(posedge clk_25Mhz or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         hCnt    <= '0;
         vCnt    <= '0;
      end else begin
         hsync_q <= Hsync;
         vsync_q <= Vsync;
         if (hRise)
            hCnt <= '0;
         else if (hCnt != CNT_MAX)
            hCnt <= hCnt + 1'b1;
         // Vsync clear has priority over a coincident line advance.
         if (vRise)
            vCnt <= '0;
         else if (hRise && vCnt != CNT_MAX)
            vCnt <= vCnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_frame_capture.sv
// Decimating frame writer: samples an IMG_W x IMG_H grid into frame memory.
// Ports: clk_25Mhz, rst_n, start, Hsync, Vsync, pixelIn in;
//        wrAddress, wrData, wrEn, busy, done, frameErr out.
// Define VGA_CAP_CONTINUOUS_EN to re-arm after every frame.
module vga_frame_capture
   import vga_pkg::*;
#(
   parameter int unsigned IMG_W   = IMG_W_DEF,
   parameter int unsigned IMG_H   = IMG_H_DEF,
   parameter int unsigned H_START = 145,
   parameter int unsigned V_START = 36,
   parameter int unsigned H_STEP  = 6,
   parameter int unsigned V_STEP  = 4
) (
   input  logic              clk_25Mhz,
   input  logic              rst_n,
   input  logic              start,
   input  logic              Hsync,
   input  logic              Vsync,
   input  logic [7:0]        pixelIn,
   output logic [ADDR_W-1:0] wrAddress,
   output logic [7:0]        wrData,
   output logic              wrEn,
   output logic              busy,
   output logic              done,
   output logic              frameErr
);

   localparam int unsigned FRAME = frame_size(IMG_W, IMG_H);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
   localparam logic [CNT_W-1:0]  H_FIRST   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0]  V_FIRST   = CNT_W'(V_START);
   localparam logic [CNT_W-1:0]  H_INC     = CNT_W'(H_STEP);
   localparam logic [CNT_W-1:0]  V_INC     = CNT_W'(V_STEP);
   localparam logic [CNT_W-1:0]  COL_LAST  = CNT_W'(IMG_W - 1);

   logic             h_rise;
   logic             v_rise;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   state_t           state;
   state_t           state_d;

   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  h_tgt;
   logic [CNT_W-1:0]  v_tgt;
   logic [CNT_W-1:0]  col;
   logic              px_sel;
   logic              last_px;

   vga_sync_tracker u_sync (
      .clk_25Mhz (clk_25Mhz),
      .rst_n     (rst_n),
      .Hsync     (Hsync),
      .Vsync     (Vsync),
      .hRise     (h_rise),
      .vRise     (v_rise),
      .hCnt      (h_cnt),
      .vCnt      (v_cnt)
   );

   // Sync edge cycles still carry the previous line's count; never sample there.
   assign px_sel = (state == CAPTURE) && !h_rise && !v_rise &&
                   (v_cnt == v_tgt) && (h_cnt == h_tgt);
   assign last_px = px_sel && (addr == LAST_ADDR);

   always_ff @(posedge clk_25Mhz or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start) state_d = WAIT_VS;
         WAIT_VS: if (v_rise) state_d = CAPTURE;
         CAPTURE: begin
            if (last_px)
               state_d = DONE;
            else if (v_rise)
               state_d = IDLE;
         end
`ifdef VGA_CAP_CONTINUOUS_EN
         DONE:    state_d = WAIT_VS;
`else
         DONE:    state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Target counters step through the sample grid without multiplies.
   always_ff @(posedge clk_25Mhz or negedge rst_n) begin
      if (!rst_n) begin
         addr  <= '0;
         h_tgt <= '0;
         v_tgt <= '0;
         col   <= '0;
      end else if (state == WAIT_VS && v_rise) begin
         addr  <= '0;
         h_tgt <= H_FIRST;
         v_tgt <= V_FIRST;
         col   <= '0;
      end else if (state == CAPTURE) begin
         if (h_rise) begin
            h_tgt <= H_FIRST;
            col   <= '0;
         end else if (px_sel) begin
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
               col   <= '0;
               v_tgt <= v_tgt + V_INC;
            end else begin
               col   <= col + 1'b1;
               h_tgt <= h_tgt + H_INC;
            end
         end
      end
   end

   // busy drops for the done cycle even when re-arming straight away.
   always_ff @(posedge clk_25Mhz or negedge rst_n) begin
      if (!rst_n) begin
         wrAddress <= '0;
         wrData    <= '0;
         wrEn      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         wrEn <= px_sel;
         if (px_sel) begin
            wrAddress <= addr;
            wrData    <= pixelIn;
         end
         done <= (state == DONE);
         busy <= (state_d == CAPTURE) || (state_d == DONE) ||
                 (state_d == WAIT_VS && state != DONE);
         if (state == IDLE && start)
            frameErr <= 1'b0;
         else if (state == CAPTURE && v_rise && !last_px)
            frameErr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a shortened sync raster.
// Ports: none (drives syncs/pixels/start, monitors the write port).
module tb_vga_frame_capture;

   localparam int IMG_W   = 4;
   localparam int IMG_H   = 2;
   localparam int H_START = 145;
   localparam int V_START = 36;
   localparam int H_STEP  = 6;
   localparam int V_STEP  = 4;
   localparam int LINE    = 166;
   localparam int FRAME_L = 42;
   localparam int HS_W    = 10;
   localparam int VS_L    = 2;
   localparam int LIMIT   = 20000;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        Hsync;
   logic        Vsync;
   logic [7:0]  pixelIn;
   logic [15:0] wrAddress;
   logic [7:0]  wrData;
   logic        wrEn;
   logic        busy;
   logic        done;
   logic        frameErr;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   wr_cnt   = 0;
   int   done_cnt = 0;
   int   cyc      = 0;
   int   last_wr  = -10;
   int   gh       = LINE - 1;
   int   gv       = FRAME_L - 1;
   int   cur_len  = FRAME_L;
   int   frame_lines = FRAME_L;
   int   bd;
   int   bw;

   vga_frame_capture #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .H_START (H_START),
      .V_START (V_START),
      .H_STEP  (H_STEP),
      .V_STEP  (V_STEP)
   ) dut (
      .clk_25Mhz (clk),
      .rst_n     (rst_n),
      .start     (start),
      .Hsync     (Hsync),
      .Vsync     (Vsync),
      .pixelIn   (pixelIn),
      .wrAddress (wrAddress),
      .wrData    (wrData),
      .wrEn      (wrEn),
      .busy      (busy),
      .done      (done),
      .frameErr  (frameErr)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(input bit ok, input string name,
                      input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Raster: Hsync rises at gh=0, Vsync at gv=0; pixel = DUT hCnt + vCnt.
   initial begin
      Hsync   = 1'b0;
      Vsync   = 1'b0;
      pixelIn = 8'h00;
      forever begin
         @(negedge clk);
         if (gh == LINE - 1) begin
            gh = 0;
            if (gv == cur_len - 1) begin
               gv = 0;
               cur_len = frame_lines;
            end else begin
               gv++;
            end
         end else begin
            gh++;
         end
         Hsync   = (gh < HS_W);
         Vsync   = (gv < VS_L);
         pixelIn = 8'(gh - 1 + gv);
      end
   end

   initial begin
      exp_t e;
      bit   prev_we;
      prev_we = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (wrEn) begin
               wr_cnt++;
               n_checks++;
               if (q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_write: addr=%0d data=%h",
                           wrAddress, wrData);
               end else begin
                  e = q.pop_front();
                  if (wrAddress !== e.a || wrData !== e.d || prev_we) begin
                     n_errors++;
                     $display("FAIL write: addr=%0d data=%h b2b=%0b required addr=%0d data=%h",
                              wrAddress, wrData, prev_we, e.a, e.d);
                  end
               end
               last_wr = cyc;
            end
            if (done) begin
               done_cnt++;
               chk(cyc == last_wr + 1 && busy == 1'b0, "done_timing",
                   cyc - last_wr, 1);
            end
            prev_we = wrEn;
         end else begin
            prev_we = 1'b0;
         end
      end
   end

   task automatic push_rows(input int n);
      exp_t e;
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            e.a = 16'(r * IMG_W + c);
            e.d = 8'(H_START + c * H_STEP + V_START + r * V_STEP);
            q.push_back(e);
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      #5 start = 1'b1;
      @(negedge clk);
      #5 start = 1'b0;
   endtask

   task automatic wait_line(input int v, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!(gv == v && gh == 0) && n < LIMIT);
      if (n >= LIMIT) chk(1'b0, name, gv, v);
   endtask

   task automatic wait_done(input int target, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (done_cnt < target && n < 2 * LIMIT);
      chk(done_cnt >= target, name, done_cnt, target);
      #5;
   endtask

   task automatic chk_zero(input string name);
      chk({wrAddress, wrData, wrEn, busy, done, frameErr} == '0, name,
          {wrAddress, wrData, wrEn, busy, done, frameErr}, 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #5 chk_zero("reset_state");
      @(negedge clk);
      #5 rst_n = 1'b1;

`ifdef VGA_CAP_CONTINUOUS_EN
      wait_line(FRAME_L - 1, "cont_lead");
      bd = done_cnt;
      bw = wr_cnt;
      push_rows(IMG_H);
      push_rows(IMG_H);
      push_rows(IMG_H);
      pulse_start();
      wait_done(bd + 3, "cont_done");
      chk(busy == 1'b1, "cont_rearm", busy, 1);
      chk(done_cnt - bd == 3, "cont_done_cnt", done_cnt - bd, 3);
      chk(wr_cnt - bw == 3 * IMG_W * IMG_H, "cont_writes",
          wr_cnt - bw, 3 * IMG_W * IMG_H);
      chk(q.size() == 0, "cont_queue", q.size(), 0);
`else
      // Full capture
      wait_line(FRAME_L - 1, "t1_lead");
      bd = done_cnt;
      bw = wr_cnt;
      push_rows(IMG_H);
      pulse_start();
      @(posedge clk);
      #5 chk(busy == 1'b1, "t1_busy", busy, 1);
      wait_done(bd + 1, "t1_done");
      chk(busy == 1'b0, "t1_busy_low", busy, 0);
      chk(frameErr == 1'b0, "t1_err", frameErr, 0);
      chk(wr_cnt - bw == IMG_W * IMG_H, "t1_writes", wr_cnt - bw, IMG_W * IMG_H);
      chk(q.size() == 0, "t1_queue", q.size(), 0);

      // Start mid-frame inside the sampled rows
      wait_line(V_START + 2, "t2_lead");
      bd = done_cnt;
      bw = wr_cnt;
      push_rows(IMG_H);
      pulse_start();
      wait_done(bd + 1, "t2_done");
      chk(wr_cnt - bw == IMG_W * IMG_H, "t2_writes", wr_cnt - bw, IMG_W * IMG_H);
      chk(q.size() == 0, "t2_queue", q.size(), 0);

      // Early Vsync: next frame is cut before the second sampled row
      wait_line(FRAME_L - 1, "t3_lead");
      bd = done_cnt;
      bw = wr_cnt;
      push_rows(1);
      pulse_start();
      frame_lines = V_START + 3;
      wait_line(1, "t3_in");
      frame_lines = FRAME_L;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!frameErr && n < LIMIT);
      #5 chk(frameErr == 1'b1, "t3_err_set", frameErr, 1);
      wait_line(4, "t3_after");
      #5 chk(busy == 1'b0, "t3_busy", busy, 0);
      chk(frameErr == 1'b1, "t3_err_sticky", frameErr, 1);
      chk(done_cnt == bd, "t3_no_done", done_cnt, bd);
      chk(wr_cnt - bw == IMG_W, "t3_writes", wr_cnt - bw, IMG_W);
      chk(q.size() == 0, "t3_queue", q.size(), 0);

      // Restart clears the error; a second start while capturing is ignored
      bd = done_cnt;
      bw = wr_cnt;
      push_rows(IMG_H);
      pulse_start();
      @(posedge clk);
      #5 chk(frameErr == 1'b0, "t5_err_clear", frameErr, 0);
      chk(busy == 1'b1, "t5_busy", busy, 1);
      wait_line(0, "t5_vs");
      wait_line(V_START + 2, "t5_mid");
      pulse_start();
      wait_done(bd + 1, "t5_done");
      chk(wr_cnt - bw == IMG_W * IMG_H, "t5_writes", wr_cnt - bw, IMG_W * IMG_H);
      chk(q.size() == 0, "t5_queue", q.size(), 0);
      wait_line(2, "t5_after");
      #5 chk(done_cnt == bd + 1, "t5_single_done", done_cnt, bd + 1);
      chk(busy == 1'b0, "t5_idle", busy, 0);

      // Reset in the middle of a capture
      bw = wr_cnt;
      push_rows(IMG_H);
      pulse_start();
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (wr_cnt < bw + 6 && n < 2 * LIMIT);
      chk(wr_cnt >= bw + 6, "t4_reach", wr_cnt - bw, 6);
      #10 rst_n = 1'b0;
      #1 chk_zero("t4_async_zero");
      q.delete();
      bd = done_cnt;
      @(negedge clk);
      #5 rst_n = 1'b1;
      wait_line(0, "t4_vs");
      wait_line(V_START + 1, "t4_after");
      #5 chk(busy == 1'b0, "t4_idle", busy, 0);
      chk(wr_cnt - bw == 6, "t4_no_writes", wr_cnt - bw, 6);
      chk(done_cnt == bd, "t4_no_done", done_cnt, bd);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
